// File: rtl/stream_permuter_pkg.sv
// rtl/stream_permuter_pkg.sv - shared mode encoding and limits for stream_permuter
package stream_permuter_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic [1:0] {
        MODE_PASS       = 2'd0,
        MODE_BITREV     = 2'd1,
        MODE_ELEMREV    = 2'd2,
        MODE_ELEMBITREV = 2'd3
    } mode_t;

endpackage

// File: rtl/stream_pipe_stage.sv
// rtl/stream_pipe_stage.sv - single valid/ready register slot
module stream_pipe_stage #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Slot accepts when empty or when its current word leaves this cycle,
    // so an empty slot fills even while downstream is stalled.
    assign in_ready = !out_valid || out_ready;

    // Load the slot; data only changes when a real word arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/stream_permuter.sv
// rtl/stream_permuter.sv - per-word bit/element permuter with elastic pipeline (option: STREAM_PERMUTER_SKID_EN)
module stream_permuter
    import stream_permuter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ELEM_W = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    localparam int N_ELEM = WIDTH / ELEM_W;
    localparam int NSTG   = (STAGES < 1) ? 1 : ((STAGES > MAX_STAGES) ? MAX_STAGES : STAGES);

    logic [WIDTH-1:0] perm_data;
    logic [NSTG:0]    lnk_valid;
    logic [NSTG:0]    lnk_ready;
    logic [WIDTH:0]   lnk_data [NSTG+1];

    // Reorder the incoming word according to the mode sampled with it.
    always_comb begin
        perm_data = i_data;
        case (mode_t'(i_mode))
            MODE_PASS: perm_data = i_data;
            MODE_BITREV: begin
                for (int i = 0; i < WIDTH; i++) begin
                    perm_data[i] = i_data[WIDTH-1-i];
                end
            end
            MODE_ELEMREV: begin
                for (int k = 0; k < N_ELEM; k++) begin
                    for (int b = 0; b < ELEM_W; b++) begin
                        perm_data[k*ELEM_W+b] = i_data[(N_ELEM-1-k)*ELEM_W+b];
                    end
                end
            end
            MODE_ELEMBITREV: begin
                for (int k = 0; k < N_ELEM; k++) begin
                    for (int b = 0; b < ELEM_W; b++) begin
                        perm_data[k*ELEM_W+b] = i_data[k*ELEM_W+ELEM_W-1-b];
                    end
                end
            end
            default: perm_data = i_data;
        endcase
    end

    generate
        for (genvar s = 0; s < NSTG; s++) begin : g_stage
            stream_pipe_stage #(.W(WIDTH + 1)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (lnk_valid[s]),
                .in_ready  (lnk_ready[s]),
                .in_data   (lnk_data[s]),
                .out_valid (lnk_valid[s+1]),
                .out_ready (lnk_ready[s+1]),
                .out_data  (lnk_data[s+1])
            );
        end
    endgenerate

    assign lnk_ready[NSTG]  = i_ready;
    assign o_valid          = lnk_valid[NSTG];
    assign {o_last, o_data} = lnk_data[NSTG];

`ifdef STREAM_PERMUTER_SKID_EN
    logic           skid_valid;
    logic           skid_valid_nx;
    logic [WIDTH:0] skid_data;
    logic           ready_q;
    logic           in_xfer;

    // Skid is bypassed when empty so latency matches the plain pipeline.
    assign in_xfer       = i_valid && ready_q;
    assign lnk_valid[0]  = skid_valid || in_xfer;
    assign lnk_data[0]   = skid_valid ? skid_data : {i_last, perm_data};
    assign skid_valid_nx = skid_valid ? !lnk_ready[0] : (in_xfer && !lnk_ready[0]);
    assign o_ready       = ready_q;

    // Park a word that stage 0 could not take; ready is registered from skid state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nx;
            ready_q    <= !skid_valid_nx;
            if (!skid_valid && in_xfer && !lnk_ready[0]) begin
                skid_data <= {i_last, perm_data};
            end
        end
    end
`else
    logic ready_en;

    assign o_ready      = ready_en && lnk_ready[0];
    assign lnk_valid[0] = i_valid && o_ready;
    assign lnk_data[0]  = {i_last, perm_data};

    // Hold off input acceptance until the first clock after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_permuter.sv
// tb/tb_stream_permuter.sv - self-checking bench for stream_permuter
module tb_stream_permuter;

`ifdef STREAM_PERMUTER_SKID_EN
    localparam int CAP = 3;
    localparam logic SKID = 1'b1;
`else
    localparam int CAP = 2;
    localparam logic SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_data = '0;
    logic [1:0]  i_mode = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_data;
    logic        o_last;

    stream_permuter #(.WIDTH(16), .ELEM_W(4), .STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_mode  (i_mode),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] word;
        int          acc;
    } sb_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  mode;
        logic        last;
        logic [15:0] exp;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[9];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        chk_lat = 1'b0;
    logic [16:0] drv_exp = '0;
    logic        stall_prev = 1'b0;
    logic [16:0] hold = '0;

    function automatic logic [15:0] perm(logic [15:0] d, logic [1:0] m);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        a = {<<{d}};
        b = {<<4{d}};
        c = {<<{b}};
        case (m)
            2'd0:    return d;
            2'd1:    return a;
            2'd2:    return b;
            default: return c;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] d, input logic [1:0] m, input logic l);
        i_valid = v;
        i_data  = d;
        i_mode  = m;
        i_last  = l;
        drv_exp = {l, perm(d, m)};
    endtask

    // One cycle: inputs were set at the negedge; sample, score, advance to next negedge.
    task automatic step(output logic acc);
        sb_t e;
        #1;
        acc = i_valid && o_ready;
        if (stall_prev) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_data", 32'({o_last, o_data}), 32'(hold));
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'({o_last, o_data}), 32'h1_0000_0);
            end else begin
                e = sb.pop_front();
                check("out_word", 32'({o_last, o_data}), 32'(e.word));
                if (chk_lat) check("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        stall_prev = o_valid && !i_ready;
        hold = {o_last, o_data};
        if (acc) sb.push_back('{drv_exp, cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic a;
        set_in(1'b0, 16'h0, 2'd0, 1'b0);
        i_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) step(a);
        step(a);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        logic pend;
        int   cnt;
        int   idx;

        vecs[0] = '{16'h1234, 2'd0, 1'b0, 16'h1234};
        vecs[1] = '{16'h1234, 2'd1, 1'b1, 16'h2C48};
        vecs[2] = '{16'h1234, 2'd2, 1'b0, 16'h4321};
        vecs[3] = '{16'h1234, 2'd3, 1'b1, 16'h84C2};
        vecs[4] = '{16'h0001, 2'd1, 1'b0, 16'h8000};
        vecs[5] = '{16'hA5F0, 2'd2, 1'b1, 16'h0F5A};
        vecs[6] = '{16'h0001, 2'd3, 1'b0, 16'h0008};
        vecs[7] = '{16'hC001, 2'd3, 1'b1, 16'h3008};
        vecs[8] = '{16'hFFFE, 2'd1, 1'b0, 16'h7FFF};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_rst", 32'(o_ready), 32'd1);
        @(negedge clk);

        // Table vectors with exact latency
        chk_lat = 1'b1;
        i_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            set_in(1'b1, vecs[v].data, vecs[v].mode, vecs[v].last);
            drv_exp = {vecs[v].last, vecs[v].exp};
            step(acc);
            check("tbl_accept", 32'(acc), 32'd1);
            set_in(1'b0, 16'h0, 2'd0, 1'b0);
            repeat (3) step(acc);
        end
        drain();
        chk_lat = 1'b0;

        // Fill with output stalled, then release
        cnt = 0;
        i_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 16'h1000 + 16'(k), 2'(k), k[0]);
            step(acc);
            if (acc) cnt++;
        end
        check("accepts_full", 32'(cnt), 32'(CAP));
        set_in(1'b0, 16'h0, 2'd0, 1'b0);
        #1;
        check("full_ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        #1;
        check("ready_path", 32'(o_ready), SKID ? 32'd0 : 32'd1);
        for (int k = 0; k < CAP; k++) begin
            #1;
            check("no_gap", 32'(o_valid), 32'd1);
            step(acc);
        end
        drain();

        // Single word, stall 3 cycles while a second arrives
        i_ready = 1'b0;
        set_in(1'b1, 16'hBEEF, 2'd2, 1'b1);
        step(acc);
        set_in(1'b1, 16'h5A3C, 2'd3, 1'b0);
        step(acc);
        check("second_accept", 32'(acc), 32'd1);
        set_in(1'b0, 16'h0, 2'd0, 1'b0);
        step(acc);
        step(acc);
        drain();

        // Random backpressure, 1000 words
        idx = 0;
        pend = 1'b0;
        for (int c = 0; c < 20000 && idx < 1000; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                set_in(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), (idx % 8) == 7);
                pend = 1'b1;
            end
            i_valid = pend;
            i_ready = 1'($urandom_range(0, 1));
            step(acc);
            if (acc) begin
                pend = 1'b0;
                idx++;
            end
        end
        check("rand_count", 32'(idx), 32'd1000);
        drain();

        // Reset with two words in flight
        i_ready = 1'b0;
        set_in(1'b1, 16'hDEAD, 2'd0, 1'b1);
        step(acc);
        set_in(1'b1, 16'hF00D, 2'd1, 1'b0);
        step(acc);
        set_in(1'b0, 16'h0, 2'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_o_valid", 32'(o_valid), 32'd0);
        check("mid_rst_o_data", 32'(o_data), 32'd0);
        check("mid_rst_o_ready", 32'(o_ready), 32'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_mid_rst", 32'(o_ready), 32'd1);
        @(negedge clk);
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stale", 32'(o_valid), 32'd0);
            step(acc);
        end
        set_in(1'b1, 16'h1234, 2'd3, 1'b1);
        step(acc);
        check("post_rst_accept", 32'(acc), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_permuter.md
STREAM_PERMUTER -- requirements
Module: stream_permuter

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be at least 2.
REQ-002 Parameter ELEM_W, default 8: element width; SHALL divide WIDTH exactly; elements are numbered from the LSB.
REQ-003 Parameter STAGES, default 2: pipeline depth, legal range 1..4.
REQ-004 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Input side: i_valid in 1, o_ready out 1, i_data in WIDTH, i_mode in 2, i_last in 1 (sideband carried alongside the data).
REQ-007 Output side: o_valid out 1, i_ready in 1, o_data out WIDTH, o_last out 1.

Function
REQ-008 A transfer SHALL occur on a side in any cycle where valid && ready; i_mode is sampled per word at transfer.
REQ-009 Mode 0 (PASS): out = in.
REQ-010 Mode 1 (BITREV): out[i] = in[WIDTH-1-i].
REQ-011 Mode 2 (ELEMREV): element k moves to position N-1-k, where N = WIDTH/ELEM_W; bit order inside each element is kept.
REQ-012 Mode 3 (ELEMBITREV): the bits inside each element are reversed; element positions are kept.
REQ-013 The permutation SHALL be applied once, combinationally, before stage 0; later stages delay only; o_last SHALL equal the i_last of the same word.
REQ-014 Stage k SHALL load when its slot is empty or stage k+1 (the output for the last stage) accepts in that cycle.
REQ-015 Bubbles SHALL collapse: a stalled output SHALL NOT block loading of empty upstream slots.
REQ-016 Latency with no backpressure SHALL be exactly STAGES cycles from input transfer to o_valid; throughput SHALL be 1 word per cycle.
REQ-017 Words SHALL leave in acceptance order, with no loss and no duplication under any i_ready pattern.
REQ-018 Once o_valid is high, o_valid, o_data and o_last SHALL hold stable until the transfer occurs.
REQ-019 Full condition: with all slots (and skid, if present) valid and i_ready low, o_ready SHALL be 0.
REQ-020 Simultaneous input and output transfer on a full pipe SHALL be allowed only when the configuration's ready path permits it (see REQ-025, REQ-026).

Reset
REQ-021 During reset, every stage valid and the skid valid SHALL be 0; o_valid = 0; o_data = 0; o_last = 0.
REQ-022 o_ready SHALL be 0 while reset is asserted and SHALL go to 1 in the first cycle after deassertion.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight words; no word accepted before reset SHALL appear afterward.

Configuration
REQ-024 Macro STREAM_PERMUTER_SKID_EN compiles in a one-entry skid buffer at the input.
REQ-025 With STREAM_PERMUTER_SKID_EN: o_ready SHALL be driven directly by a flop (= !skid_valid); capacity is STAGES+1 words; there is no combinational path from i_ready to o_ready.
REQ-026 Without STREAM_PERMUTER_SKID_EN: o_ready = stage-0 load enable (combinational from i_ready through the stage chain); capacity is STAGES words.
REQ-027 Latency (REQ-016) SHALL be identical with and without the macro when the skid is empty.

Structure
REQ-028 Package stream_permuter_pkg SHALL hold the mode typedef (MODE_PASS=0, MODE_BITREV=1, MODE_ELEMREV=2, MODE_ELEMBITREV=3) and the MAX_STAGES=4 constant.
REQ-029 One sub-module, stream_pipe_stage (single valid/ready register slot, parametrised width), SHALL be instantiated STAGES times; the permutation stays in the top level.

Verification (WIDTH=16, ELEM_W=4, STAGES=2)
REQ-030 i_data=16'h1234 in modes 0/1/2/3, i_ready=1 -> o_data=1234/2C48/4321/84C2, each arriving exactly 2 cycles after its transfer.
REQ-031 i_valid held high for 10 cycles, i_ready=0 -> o_ready falls after 2 accepts (3 with SKID_EN); on release, all words leave in order with no gap.
REQ-032 i_ready random at 50%, 1000 words, with i_last on every 8th word -> scoreboard matches all data and last bits; o_data stable whenever a stall holds.
REQ-033 Single word, then i_ready=0 for 3 cycles while a second word arrives -> both words delivered in order with the second kept; the first held stable.
REQ-034 Reset pulsed with 2 words in flight -> o_valid=0 immediately and no stale word after reset; o_ready=1 on the first cycle after release.
REQ-035 Build both with and without STREAM_PERMUTER_SKID_EN -> identical output streams; with the macro, o_ready is checked to be a pure flop output.
